change_dispenser: RTL and testbench

Change-return unit on the far side of the vending machine's coin interface: the machine accepts coins and raises change, while this block pays change back out as coin codes. It takes a refund amount in 5-unit steps, dispenses coins greedily (largest first) from per-denomination inventory counters, and presents one coin at a time to the hopper over a valid/ready handshake. It sits between the vending machine controller and the coin hopper driver.

---
 rtl/change_dispenser.sv | 208 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy change-return unit paying a refund out as coin codes.
// Latency: first coin offered two cycles after req; one bubble cycle between coins.
// Backpressure: an offered coin holds until coin_ready; optional watchdog
// (CHANGE_TIMEOUT_EN) withdraws it after TIMEOUT stalled cycles.
module change_dispenser #(
  parameter int AMT_W    = 6,
  parameter int CNT_W    = 4,
  parameter int INIT_CNT = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amt,
  input  logic             load,
  input  logic [CNT_W-1:0] load_n5,
  input  logic [CNT_W-1:0] load_n10,
  input  logic [CNT_W-1:0] load_n20,
  output logic [1:0]       coin,
  output logic             coin_valid,
  input  logic             coin_ready,
  output logic             busy,
  output logic             done,
  output logic             short
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0]       COIN_NONE = 2'b00;
  localparam logic [1:0]       COIN_5    = 2'b01;
  localparam logic [1:0]       COIN_10   = 2'b10;
  localparam logic [1:0]       COIN_20   = 2'b11;
  localparam logic [CNT_W-1:0] INIT_V    = CNT_W'(INIT_CNT);

  // A watchdog limit of zero would withdraw a coin before it is ever offered.
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("change_dispenser: TIMEOUT must be at least 1");
  end

  state_t           state, state_nxt;
  logic [AMT_W-1:0] rem, rem_nxt;
  logic [CNT_W-1:0] cnt5, cnt5_nxt;
  logic [CNT_W-1:0] cnt10, cnt10_nxt;
  logic [CNT_W-1:0] cnt20, cnt20_nxt;
  logic [1:0]       coin_q, coin_nxt;
  logic             short_q, short_nxt;

  // Denomination is usable only if it fits in the remainder and is in stock,
  // which is what keeps rem and the counters from ever underflowing.
  logic can_20, can_10, can_5;
  assign can_20 = (rem >= AMT_W'(4)) && (cnt20 != '0);
  assign can_10 = (rem >= AMT_W'(2)) && (cnt10 != '0);
  assign can_5  = (rem >= AMT_W'(1)) && (cnt5  != '0);

  // Value of a coin code in 5-unit steps.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  coin_value = AMT_W'(1);
      COIN_10: coin_value = AMT_W'(2);
      COIN_20: coin_value = AMT_W'(4);
      default: coin_value = '0;
    endcase
  endfunction

`ifdef CHANGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd, wd_nxt;
  logic            wd_expire;

  // The current cycle is the TIMEOUT-th consecutive stalled ISSUE cycle.
  assign wd_expire = (wd == WD_W'(TIMEOUT - 1));
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath updates for remainder, inventory, coin and short flag.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    cnt5_nxt  = cnt5;
    cnt10_nxt = cnt10;
    cnt20_nxt = cnt20;
    coin_nxt  = coin_q;
    short_nxt = short_q;
`ifdef CHANGE_TIMEOUT_EN
    wd_nxt    = wd;
`endif

    case (state)
      IDLE: begin
        if (req) begin
          // A simultaneous restock is dropped: the refund takes priority.
          rem_nxt   = amt;
          short_nxt = 1'b0;
          state_nxt = SELECT;
        end else if (load) begin
          cnt5_nxt  = load_n5;
          cnt10_nxt = load_n10;
          cnt20_nxt = load_n20;
        end
      end

      SELECT: begin
`ifdef CHANGE_TIMEOUT_EN
        wd_nxt = '0;
`endif
        if (can_20) begin
          coin_nxt  = COIN_20;
          state_nxt = ISSUE;
        end else if (can_10) begin
          coin_nxt  = COIN_10;
          state_nxt = ISSUE;
        end else if (can_5) begin
          coin_nxt  = COIN_5;
          state_nxt = ISSUE;
        end else begin
          // Nothing usable: either fully paid or out of suitable coins.
          short_nxt = (rem != '0);
          state_nxt = DONE;
        end
      end

      ISSUE: begin
        if (coin_ready) begin
          rem_nxt = rem - coin_value(coin_q);
          case (coin_q)
            COIN_5:  cnt5_nxt  = cnt5  - CNT_W'(1);
            COIN_10: cnt10_nxt = cnt10 - CNT_W'(1);
            COIN_20: cnt20_nxt = cnt20 - CNT_W'(1);
            default: ;
          endcase
`ifdef CHANGE_TIMEOUT_EN
          wd_nxt = '0;
`endif
          state_nxt = SELECT;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (wd_expire) begin
          // Withdraw the coin; rem and inventory keep the unpaid amount.
          short_nxt = 1'b1;
          state_nxt = DONE;
        end else begin
          wd_nxt = wd + WD_W'(1);
        end
`endif
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers; reset restores a full default inventory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem     <= '0;
      cnt5    <= INIT_V;
      cnt10   <= INIT_V;
      cnt20   <= INIT_V;
      coin_q  <= COIN_NONE;
      short_q <= 1'b0;
    end else begin
      rem     <= rem_nxt;
      cnt5    <= cnt5_nxt;
      cnt10   <= cnt10_nxt;
      cnt20   <= cnt20_nxt;
      coin_q  <= coin_nxt;
      short_q <= short_nxt;
    end
  end

`ifdef CHANGE_TIMEOUT_EN
  // Consecutive-stall watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= '0;
    end else begin
      wd <= wd_nxt;
    end
  end
`endif

  // All outputs are state decodes or registers.
  assign coin       = (state == ISSUE) ? coin_q : COIN_NONE;
  assign coin_valid = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign short      = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [5:0] amt = '0;
  logic       load = 1'b0;
  logic [3:0] load_n5 = '0;
  logic [3:0] load_n10 = '0;
  logic [3:0] load_n20 = '0;
  logic [1:0] coin;
  logic       coin_valid;
  logic       coin_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       short;

  int tests = 0;
  int fails = 0;

  change_dispenser #(
    .AMT_W(6), .CNT_W(4), .INIT_CNT(8), .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .amt        (amt),
    .load       (load),
    .load_n5    (load_n5),
    .load_n10   (load_n10),
    .load_n20   (load_n20),
    .coin       (coin),
    .coin_valid (coin_valid),
    .coin_ready (coin_ready),
    .busy       (busy),
    .done       (done),
    .short      (short)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] e_coin, input logic e_valid,
                         input logic e_busy, input logic e_done, input logic e_short);
    chk({tag, ".coin"},  32'(coin),       32'(e_coin));
    chk({tag, ".valid"}, 32'(coin_valid), 32'(e_valid));
    chk({tag, ".busy"},  32'(busy),       32'(e_busy));
    chk({tag, ".done"},  32'(done),       32'(e_done));
    chk({tag, ".short"}, 32'(short),      32'(e_short));
  endtask

  task automatic chk_inv(input string tag, input int e20, input int e10, input int e5, input int e_rem);
    chk({tag, ".n20"}, 32'(dut.cnt20), 32'(e20));
    chk({tag, ".n10"}, 32'(dut.cnt10), 32'(e10));
    chk({tag, ".n5"},  32'(dut.cnt5),  32'(e5));
    chk({tag, ".rem"}, 32'(dut.rem),   32'(e_rem));
  endtask

  initial begin
    // ---- reset ----
    tick(); tick();
    chk_out("reset", 2'b00, 0, 0, 0, 0);
    chk_inv("reset", 8, 8, 8, 0);
    rst = 1'b0;
    tick();

    // ---- amt=7 (35): coins 20,10,5 with bubbles ----
    coin_ready = 1'b1;
    amt = 6'd7; req = 1'b1;
    tick();                       // T: SELECT
    req = 1'b0;
    chk_out("r35.sel", 2'b00, 0, 1, 0, 0);
    tick();                       // ISSUE 20
    chk_out("r35.c20", 2'b11, 1, 1, 0, 0);
    tick();                       // accept -> SELECT (bubble)
    chk_out("r35.bub1", 2'b00, 0, 1, 0, 0);
    chk_inv("r35.after20", 7, 8, 8, 3);
    tick();
    chk_out("r35.c10", 2'b10, 1, 1, 0, 0);
    tick();
    chk_out("r35.bub2", 2'b00, 0, 1, 0, 0);
    chk_inv("r35.after10", 7, 7, 8, 1);
    tick();
    chk_out("r35.c5", 2'b01, 1, 1, 0, 0);
    tick();                       // last accept -> SELECT
    chk_out("r35.bub3", 2'b00, 0, 1, 0, 0);
    tick();
    chk_out("r35.done", 2'b00, 0, 1, 1, 0);
    tick();
    chk_out("r35.idle", 2'b00, 0, 0, 0, 0);
    chk_inv("r35.end", 7, 7, 7, 0);

    // ---- restock 0/1/1 then amt=6 (30): coins 10,5, short with rem 3 ----
    load = 1'b1; load_n20 = 4'd0; load_n10 = 4'd1; load_n5 = 4'd1;
    tick();
    load = 1'b0;
    chk_inv("load1", 0, 1, 1, 0);
    amt = 6'd6; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk_out("r30.c10", 2'b10, 1, 1, 0, 0);
    tick(); tick();
    chk_out("r30.c5", 2'b01, 1, 1, 0, 0);
    tick(); tick();
    chk_out("r30.done", 2'b00, 0, 1, 1, 1);
    chk_inv("r30.end", 0, 0, 0, 3);
    tick();
    chk_out("r30.idle", 2'b00, 0, 0, 0, 1);

    // ---- amt=0: done exactly two edges after req, short cleared ----
    amt = 6'd0; req = 1'b1;
    tick();
    req = 1'b0;
    chk_out("r0.sel", 2'b00, 0, 1, 0, 0);
    tick();
    chk_out("r0.done", 2'b00, 0, 1, 1, 0);
    tick();
    chk_out("r0.idle", 2'b00, 0, 0, 0, 0);

    // ---- restock 5/5/5, amt=2 with 5-cycle hopper stall ----
    load = 1'b1; load_n20 = 4'd5; load_n10 = 4'd5; load_n5 = 4'd5;
    tick();
    load = 1'b0;
    coin_ready = 1'b0;
    amt = 6'd2; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_out("stall", 2'b10, 1, 1, 0, 0);
      chk_inv("stall", 5, 5, 5, 2);
      tick();
    end
    coin_ready = 1'b1;
    tick();                       // accept edge
    chk_out("stall.acc", 2'b00, 0, 1, 0, 0);
    chk_inv("stall.acc", 5, 4, 5, 0);
    tick();
    chk_out("stall.done", 2'b00, 0, 1, 1, 0);
    tick();

    // ---- req/load ignored while busy, then reset mid-ISSUE ----
    coin_ready = 1'b0;
    amt = 6'd4; req = 1'b1;
    tick();                       // SELECT
    amt = 6'd1; req = 1'b1; load = 1'b1;
    load_n20 = 4'd1; load_n10 = 4'd1; load_n5 = 4'd1;
    tick();                       // ISSUE 20
    req = 1'b0; load = 1'b0;
    chk_out("busy.ign", 2'b11, 1, 1, 0, 0);
    chk_inv("busy.ign", 5, 4, 5, 4);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk_inv("busy.ign2", 5, 4, 5, 4);
    rst = 1'b1;
    #1;
    chk_out("midrst", 2'b00, 0, 0, 0, 0);
    chk_inv("midrst", 8, 8, 8, 0);
    tick();
    rst = 1'b0;
    tick();
    chk_out("postrst", 2'b00, 0, 0, 0, 0);

`ifdef CHANGE_TIMEOUT_EN
    // ---- watchdog: coin withdrawn after 16 stalled cycles ----
    begin
      int n;
      coin_ready = 1'b0;
      amt = 6'd1; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      n = 0;
      while (coin_valid && n < 40) begin
        n++;
        tick();
      end
      chk("wd.cycles", 32'(n), 32'd16);
      chk_out("wd.done", 2'b00, 0, 1, 1, 1);
      chk_inv("wd.inv", 8, 8, 8, 1);
      tick();
      chk_out("wd.idle", 2'b00, 0, 0, 0, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
